move_enumerator: RTL

- Consumer of the registered count-trailing-zeros stage next_bit_pos: 64-bit board in, lowest set-bit index out one clock later.
- Accepts one legal-move bitboard per transaction and serialises it into square indices, LSB first, one per cycle under valid/ready backpressure.
- Produces a pass beat for an empty board.
- Sits between move generation and the search/flip datapath.

---
 rtl/move_enumerator.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/move_enumerator.sv
// move_enumerator: serialises a 64-bit legal-move bitboard into square
// indices, lowest square first, one beat per cycle under valid/ready.
// An empty board yields a single pass beat (EMIT_PASS=1) or an out_empty
// pulse (EMIT_PASS=0).
// Optional build macro MOVE_ENUM_COUNT_EN adds out_count (moves on the
// board) and out_index (ordinal of the current beat).

// next_bit_pos: registered count-trailing-zeros stage. pos is the index of
// the lowest set bit of the board presented one clock earlier (0 for 0).
module next_bit_pos (
  input  logic        clock,
  input  logic        rstn,
  input  logic [63:0] board,
  output logic [5:0]  pos
);

  function automatic logic [5:0] ctz64(input logic [63:0] b);
    logic [5:0] p;
    p = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (b[i]) begin
        p = i[5:0];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  // Register the lowest set-bit index of the incoming board.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      pos <= 6'd0;
    end else begin
      pos <= ctz64(board);
    end
  end

endmodule

module move_enumerator #(
  parameter bit EMIT_PASS = 1'b1
) (
  input  logic        clock,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_moves,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_pos,
  output logic        out_pass,
  output logic        out_last,
  output logic        out_empty
`ifdef MOVE_ENUM_COUNT_EN
  ,
  output logic [6:0]  out_count,
  output logic [5:0]  out_index
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [63:0] cur_r;
  logic [63:0] cur_next_s;
  logic        pass_r;
  logic        pass_next_s;
  logic        empty_r;
  logic        empty_next_s;
  logic        in_hs_s;
  logic        out_hs_s;
  logic        emit_s;
  logic        last_s;
  logic [63:0] cur_rest_s;

  // The ctz stage sees cur's D-input, so its output tracks ctz(cur) with no bubble.
  next_bit_pos u_next_bit_pos (
    .clock (clock),
    .rstn  (rstn),
    .board (cur_next_s),
    .pos   (out_pos)
  );

  assign emit_s     = (state_r == ST_EMIT);
  assign cur_rest_s = cur_r & (cur_r - 64'd1);
  assign last_s     = (cur_rest_s == 64'd0);
  assign in_ready   = (state_r == ST_IDLE);
  assign out_valid  = emit_s;
  assign out_pass   = pass_r;
  assign out_last   = emit_s & last_s;
  assign out_empty  = empty_r;
  assign in_hs_s    = in_valid & in_ready;
  assign out_hs_s   = out_valid & out_ready;

  // Next-state logic: accept a board in IDLE, peel off the lowest move per handshake in EMIT.
  always_comb begin
    state_next_s = state_r;
    cur_next_s   = cur_r;
    pass_next_s  = pass_r;
    empty_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_hs_s) begin
          if (in_moves != 64'd0) begin
            cur_next_s   = in_moves;
            pass_next_s  = 1'b0;
            state_next_s = ST_EMIT;
          end else if (EMIT_PASS) begin
            cur_next_s   = 64'd0;
            pass_next_s  = 1'b1;
            state_next_s = ST_EMIT;
          end else begin
            empty_next_s = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (abort) begin
          // A beat handshaken this cycle is still delivered; the rest is dropped.
          cur_next_s   = 64'd0;
          pass_next_s  = 1'b0;
          state_next_s = ST_IDLE;
        end else if (out_hs_s) begin
          if (last_s) begin
            cur_next_s   = 64'd0;
            pass_next_s  = 1'b0;
            state_next_s = ST_IDLE;
          end else begin
            cur_next_s = cur_rest_s;
          end
        end else begin
          // Backpressure: everything holds so outputs stay stable.
          cur_next_s = cur_r;
        end
      end
      default: begin
        cur_next_s   = 64'd0;
        pass_next_s  = 1'b0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, remaining-move and flag registers.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      cur_r   <= 64'd0;
      pass_r  <= 1'b0;
      empty_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cur_r   <= cur_next_s;
      pass_r  <= pass_next_s;
      empty_r <= empty_next_s;
    end
  end

`ifdef MOVE_ENUM_COUNT_EN
  function automatic logic [6:0] popcnt64(input logic [63:0] b);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'd0, b[i]};
    end
    return n;
  endfunction

  logic [6:0] count_r;
  logic [5:0] index_r;

  assign out_count = count_r;
  assign out_index = index_r;

  // Latch the move count at accept and step the beat ordinal on each handshake.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      count_r <= 7'd0;
      index_r <= 6'd0;
    end else if (in_hs_s) begin
      count_r <= popcnt64(in_moves);
      index_r <= 6'd0;
    end else if (out_hs_s) begin
      count_r <= count_r;
      index_r <= index_r + 6'd1;
    end else begin
      count_r <= count_r;
      index_r <= index_r;
    end
  end
`endif

endmodule
